contador_pulsos: RTL and testbench
==================================

# contador_pulsos

Parameterizable up/down event counter that consumes the single-cycle pulses produced by the edge-detection stage and accumulates them into a bounded count. In the 8-bit counter design it sits directly downstream of the negative-edge detectors: one detector feeds the increment input and another feeds the decrement input. Its count output drives the display/LED stage. It supports a synchronous parallel load, modulo wrap or saturation, and registered overflow/underflow event pulses.

## Interface
- ANCHO, 8: count width in bits.
- MODULO, 256: count range is 0..MODULO-1. Legal values are 2 ≤ MODULO ≤ 2^ANCHO.
- SATURAR, 0: 0 = wrap at the limits; 1 = hold at the limits.
- iClk  input  1  system clock; all state is updated on the rising edge.
- iReset_n  input  1  reset. Asynchronous assertion, active-low.
- iHabilitar  input  1  when 0, increment and decrement pulses are ignored. Does not gate load.
- iIncremento  input  1  increment request; single-cycle pulse from the upstream edge detector.
- iDecremento  input  1  decrement request; single-cycle pulse from the upstream edge detector.
- iCarga  input  1  synchronous load strobe.
- iDato  input  ANCHO  load value.
- oCuenta  output  ANCHO  current count (registered).
- oCero  output  1  high when oCuenta == 0. Decoded from the count register.
- oMaximo  output  1  high when oCuenta == MODULO-1. Decoded from the count register.
- oDesborde  output  1  one-cycle overflow event pulse (registered).
- oSubdesborde  output  1  one-cycle underflow event pulse (registered).

## Operation
- Reset: iReset_n = 0 immediately forces oCuenta = 0, oDesborde = 0 and oSubdesborde = 0, independent of iClk. As a result oCero = 1 and oMaximo = 0 during reset.
- Reset release: counting resumes on the first rising edge after iReset_n returns to 1.
- Per-edge priority, highest first:
  1. iCarga = 1: oCuenta ← iDato. If iDato > MODULO-1, oCuenta ← MODULO-1. No event pulses are generated.
  2. iHabilitar = 0: oCuenta holds.
  3. iIncremento = 1 and iDecremento = 1 together: the two requests cancel; oCuenta holds and no pulse is generated.
  4. iIncremento = 1 only:
     - below MODULO-1: oCuenta + 1.
     - at MODULO-1 with SATURAR = 0: oCuenta wraps to 0 and oDesborde = 1.
     - at MODULO-1 with SATURAR = 1: oCuenta holds at MODULO-1 and oDesborde = 1 (flags the lost event).
  5. iDecremento = 1 only:
     - above 0: oCuenta − 1.
     - at 0 with SATURAR = 0: oCuenta wraps to MODULO-1 and oSubdesborde = 1.
     - at 0 with SATURAR = 1: oCuenta holds at 0 and oSubdesborde = 1.
  6. Otherwise: oCuenta holds.
- oDesborde and oSubdesborde are 0 on every edge where their condition is absent. They are never both 1 in the same cycle.
- Request inputs are level-sampled: a request held high for N cycles counts N times. The upstream detector guarantees 1-cycle pulses.
- Arithmetic: next-count logic compares against the constant MODULO-1 before adding or subtracting, so no intermediate value exceeds ANCHO bits. Non-power-of-2 MODULO wraps at MODULO-1, not at 2^ANCHO-1.

## Timing
- Latency: a request sampled at rising edge k is reflected on oCuenta, oCero, oMaximo and the event pulses from edge k until edge k+1.
- End-to-end: one input falling edge reaches the count in 3 clock cycles (2-cycle detector latency plus 1 cycle here).
- Back-to-back pulses on consecutive cycles each count; throughput is one event per clock.
- iCarga is synchronous. A load coincident with an increment takes the load value; the increment is dropped without a pulse.
- Reset mid-operation, including while an event pulse is high: all outputs are cleared asynchronously in the same cycle.
- No combinational path from any input to any output. oCero and oMaximo depend only on the count register.

## Test plan
- Reset and enable: hold iReset_n = 0, then release. Pulse iIncremento 5 times with iHabilitar = 1 → oCuenta = 5. With iHabilitar = 0, 3 more pulses → oCuenta stays 5.
- Wrap (MODULO = 10, SATURAR = 0):
  - load 9 then pulse iIncremento → oCuenta = 0, oDesborde high for exactly 1 cycle.
  - from 0, pulse iDecremento → oCuenta = 9, oSubdesborde high for 1 cycle.
- Saturate (MODULO = 256, SATURAR = 1): load 255 then increment → oCuenta = 255, oMaximo = 1, oDesborde pulses once. Load 0 then decrement → oCuenta = 0, oSubdesborde pulses once.
- Priority and clamp:
  - iCarga = 1, iDato = 0x42 together with iIncremento = 1 → oCuenta = 0x42, no pulse.
  - simultaneous increment and decrement at 7 → oCuenta stays 7.
  - MODULO = 10, iDato = 200 → oCuenta = 9.
- Async reset mid-count: at count 0x80, assert iReset_n = 0 between clock edges → oCuenta = 0 and oCero = 1 before the next edge. An event pulse pending at that moment is cleared.
- Throughput: drive iIncremento high for 4 consecutive cycles from 0 → oCuenta reads 1, 2, 3, 4 on successive cycles.

Source files
------------

// File: rtl/contador_pulsos.sv
// rtl/contador_pulsos.sv - up/down pulse counter with load, modulo wrap or saturation, and event pulses
module contador_pulsos #(
    parameter int ANCHO   = 8,
    parameter int MODULO  = 256,
    parameter int SATURAR = 0
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iHabilitar,
    input  logic             iIncremento,
    input  logic             iDecremento,
    input  logic             iCarga,
    input  logic [ANCHO-1:0] iDato,
    output logic [ANCHO-1:0] oCuenta,
    output logic             oCero,
    output logic             oMaximo,
    output logic             oDesborde,
    output logic             oSubdesborde
);

    localparam logic [ANCHO-1:0] LP_MAX = ANCHO'(MODULO - 1);
    localparam logic             LP_SAT = (SATURAR != 0);

    logic [ANCHO-1:0] r_cuenta;
    logic             r_desborde;
    logic             r_subdesborde;

    logic [ANCHO-1:0] w_cuenta_sig;
    logic             w_desborde_sig;
    logic             w_subdesborde_sig;

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            r_cuenta      <= '0;
            r_desborde    <= 1'b0;
            r_subdesborde <= 1'b0;
        end else begin
            r_cuenta      <= w_cuenta_sig;
            r_desborde    <= w_desborde_sig;
            r_subdesborde <= w_subdesborde_sig;
        end
    end

    // Limits are checked before the +/-1 so the sum never needs an extra bit.
    always_comb begin
        w_cuenta_sig      = r_cuenta;
        w_desborde_sig    = 1'b0;
        w_subdesborde_sig = 1'b0;
        if (iCarga) begin
            w_cuenta_sig = (iDato > LP_MAX) ? LP_MAX : iDato;
        end else if (iHabilitar && (iIncremento != iDecremento)) begin
            if (iIncremento) begin
                if (r_cuenta == LP_MAX) begin
                    w_cuenta_sig   = LP_SAT ? LP_MAX : '0;
                    w_desborde_sig = 1'b1;
                end else begin
                    w_cuenta_sig = r_cuenta + 1'b1;
                end
            end else begin
                if (r_cuenta == '0) begin
                    w_cuenta_sig      = LP_SAT ? '0 : LP_MAX;
                    w_subdesborde_sig = 1'b1;
                end else begin
                    w_cuenta_sig = r_cuenta - 1'b1;
                end
            end
        end
    end

    assign oCuenta      = r_cuenta;
    assign oCero        = (r_cuenta == '0);
    assign oMaximo      = (r_cuenta == LP_MAX);
    assign oDesborde    = r_desborde;
    assign oSubdesborde = r_subdesborde;

endmodule

// File: tb/tb_contador_pulsos.sv
// tb/tb_contador_pulsos.sv - bench for contador_pulsos: wrap-256, modulo-10 and saturating instances share stimulus
module tb_contador_pulsos;

    typedef struct packed {
        logic       car;
        logic [7:0] dato;
        logic       hab;
        logic       inc;
        logic       dec;
        logic [7:0] ea;
        logic [7:0] ew;
        logic [7:0] es;
        logic [2:0] ed;
        logic [2:0] eu;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       car, hab, inc, dec;
    logic [7:0] dato;

    logic [7:0] ca, cw, cs;
    logic       za, zw, zs, ma, mw, ms;
    logic       da, dw, ds, ua, uw, us;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    contador_pulsos #(.ANCHO(8), .MODULO(256), .SATURAR(0)) dut_a (
        .iClk(clk), .iReset_n(rst_n), .iHabilitar(hab), .iIncremento(inc),
        .iDecremento(dec), .iCarga(car), .iDato(dato), .oCuenta(ca),
        .oCero(za), .oMaximo(ma), .oDesborde(da), .oSubdesborde(ua)
    );

    contador_pulsos #(.ANCHO(8), .MODULO(10), .SATURAR(0)) dut_w (
        .iClk(clk), .iReset_n(rst_n), .iHabilitar(hab), .iIncremento(inc),
        .iDecremento(dec), .iCarga(car), .iDato(dato), .oCuenta(cw),
        .oCero(zw), .oMaximo(mw), .oDesborde(dw), .oSubdesborde(uw)
    );

    contador_pulsos #(.ANCHO(8), .MODULO(256), .SATURAR(1)) dut_s (
        .iClk(clk), .iReset_n(rst_n), .iHabilitar(hab), .iIncremento(inc),
        .iDecremento(dec), .iCarga(car), .iDato(dato), .oCuenta(cs),
        .oCero(zs), .oMaximo(ms), .oDesborde(ds), .oSubdesborde(us)
    );

    task automatic chk(input string nm, input int idx, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic [7:0] d, input logic h, input logic i, input logic de,
                       input logic [7:0] ea, input logic [7:0] ew, input logic [7:0] es,
                       input logic [2:0] ed, input logic [2:0] eu);
        vec_t v;
        v = '{car: c, dato: d, hab: h, inc: i, dec: de, ea: ea, ew: ew, es: es, ed: ed, eu: eu};
        tbl.push_back(v);
    endtask

    initial begin
        //   car dato   hab inc dec   A      W     S     dsb     sub
        add(0, 8'd0,   1, 1, 0, 8'd1,   8'd1, 8'd1,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd2,   8'd2, 8'd2,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd3,   8'd3, 8'd3,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd4,   8'd4, 8'd4,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd5,   8'd5, 8'd5,   3'b000, 3'b000);
        add(0, 8'd0,   1, 0, 0, 8'd5,   8'd5, 8'd5,   3'b000, 3'b000);
        add(0, 8'd0,   0, 1, 0, 8'd5,   8'd5, 8'd5,   3'b000, 3'b000);
        add(0, 8'd0,   0, 1, 0, 8'd5,   8'd5, 8'd5,   3'b000, 3'b000);
        add(0, 8'd0,   0, 1, 0, 8'd5,   8'd5, 8'd5,   3'b000, 3'b000);
        add(1, 8'd9,   1, 0, 0, 8'd9,   8'd9, 8'd9,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd10,  8'd0, 8'd10,  3'b010, 3'b000);
        add(0, 8'd0,   1, 0, 0, 8'd10,  8'd0, 8'd10,  3'b000, 3'b000);
        add(0, 8'd0,   1, 0, 1, 8'd9,   8'd9, 8'd9,   3'b000, 3'b010);
        add(1, 8'd255, 1, 0, 0, 8'd255, 8'd9, 8'd255, 3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd0,   8'd0, 8'd255, 3'b111, 3'b000);
        add(0, 8'd0,   1, 0, 0, 8'd0,   8'd0, 8'd255, 3'b000, 3'b000);
        add(1, 8'd0,   1, 0, 0, 8'd0,   8'd0, 8'd0,   3'b000, 3'b000);
        add(0, 8'd0,   1, 0, 1, 8'd255, 8'd9, 8'd0,   3'b000, 3'b111);
        add(1, 8'h42,  1, 1, 0, 8'h42,  8'd9, 8'h42,  3'b000, 3'b000);
        add(1, 8'd7,   1, 0, 0, 8'd7,   8'd7, 8'd7,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 1, 8'd7,   8'd7, 8'd7,   3'b000, 3'b000);
        add(1, 8'd200, 1, 0, 0, 8'd200, 8'd9, 8'd200, 3'b000, 3'b000);
        add(0, 8'd0,   0, 0, 1, 8'd200, 8'd9, 8'd200, 3'b000, 3'b000);
        add(1, 8'd0,   0, 0, 0, 8'd0,   8'd0, 8'd0,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd1,   8'd1, 8'd1,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd2,   8'd2, 8'd2,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd3,   8'd3, 8'd3,   3'b000, 3'b000);
        add(0, 8'd0,   1, 1, 0, 8'd4,   8'd4, 8'd4,   3'b000, 3'b000);
        add(0, 8'd0,   1, 0, 1, 8'd3,   8'd3, 8'd3,   3'b000, 3'b000);

        rst_n = 1'b0; car = 1'b0; hab = 1'b1; inc = 1'b1; dec = 1'b0; dato = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cuenta_a", 0, ca, 8'd0);
        chk("rst_cuenta_s", 0, cs, 8'd0);
        chk("rst_cero_a", 0, {7'b0, za}, 8'd1);
        chk("rst_max_a", 0, {7'b0, ma}, 8'd0);
        chk("rst_pulsos", 0, {2'b0, da, dw, ds, ua, uw, us}, 8'd0);

        @(negedge clk);
        inc = 1'b0;
        rst_n = 1'b1;

        for (int k = 0; k < tbl.size(); k++) begin
            @(negedge clk);
            car = tbl[k].car; dato = tbl[k].dato; hab = tbl[k].hab;
            inc = tbl[k].inc; dec = tbl[k].dec;
            @(posedge clk);
            #1;
            chk("cuenta_a", k, ca, tbl[k].ea);
            chk("cuenta_w", k, cw, tbl[k].ew);
            chk("cuenta_s", k, cs, tbl[k].es);
            chk("cero", k, {5'b0, za, zw, zs},
                {5'b0, tbl[k].ea == 8'd0, tbl[k].ew == 8'd0, tbl[k].es == 8'd0});
            chk("maximo", k, {5'b0, ma, mw, ms},
                {5'b0, tbl[k].ea == 8'd255, tbl[k].ew == 8'd9, tbl[k].es == 8'd255});
            chk("desborde", k, {5'b0, da, dw, ds}, {5'b0, tbl[k].ed});
            chk("subdesborde", k, {5'b0, ua, uw, us}, {5'b0, tbl[k].eu});
        end

        // Async reset between edges while a wrap pulse is high on the modulo-10 instance.
        @(negedge clk);
        car = 1'b1; dato = 8'h7F; hab = 1'b1; inc = 1'b0; dec = 1'b0;
        @(negedge clk);
        car = 1'b0; inc = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_cuenta_a", 100, ca, 8'h80);
        chk("pre_rst_desb_w", 100, {7'b0, dw}, 8'd1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_cuenta_a", 101, ca, 8'd0);
        chk("async_cero_a", 101, {7'b0, za}, 8'd1);
        chk("async_cuenta_s", 101, cs, 8'd0);
        chk("async_desb_w", 101, {7'b0, dw}, 8'd0);
        @(posedge clk);
        #1;
        chk("held_rst_cuenta_a", 102, ca, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("release_cuenta_a", 103, ca, 8'd1);
        chk("release_cuenta_w", 103, cw, 8'd1);
        inc = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
